// File: rtl/alu_arbiter_pkg.sv
// ==================================================================
// alu_arbiter_pkg: datapath types, ALU codes and shared request struct
// Rev 1.0
// ==================================================================
`default_nettype none

package alu_arbiter_pkg;

  typedef logic [31:0] DataPath;
  typedef logic [2:0]  ALUCodePath;
  typedef logic [6:0]  Funct7Path;
  typedef logic [4:0]  ShamtPath;

  localparam ALUCodePath c_ALU_ADD_SUB = 3'd0;
  localparam ALUCodePath c_ALU_SLL     = 3'd1;
  localparam ALUCodePath c_ALU_SLT     = 3'd2;
  localparam ALUCodePath c_ALU_SLTU    = 3'd3;
  localparam ALUCodePath c_ALU_XOR     = 3'd4;
  localparam ALUCodePath c_ALU_SRL_SRA = 3'd5;
  localparam ALUCodePath c_ALU_OR      = 3'd6;
  localparam ALUCodePath c_ALU_AND     = 3'd7;

  localparam Funct7Path c_FUNCT7_SRL = 7'h00;
  localparam Funct7Path c_FUNCT7_SRA = 7'h20;

  localparam DataPath c_ALU_ILLEGAL = 32'hcdcdcdcd;

  typedef struct packed {
    DataPath    a;
    DataPath    b;
    ALUCodePath code;
    Funct7Path  funct7;
  } ALUReqPath;

  function automatic ShamtPath get_shamt(input ShamtPath b_lo);
    return b_lo;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
// ==================================================================
// alu: team combinational ALU
// Rev 1.0
// ==================================================================
`default_nettype none

module alu
  import alu_arbiter_pkg::*;
(
  input  DataPath    i_a,
  input  DataPath    i_b,
  input  ALUCodePath i_code,
  input  Funct7Path  i_funct7,
  output DataPath    o_out
);

  ShamtPath w_shamt;
  assign w_shamt = get_shamt(i_b[4:0]);

  always_comb begin
    o_out = '0;
    case (i_code)
      c_ALU_ADD_SUB: o_out = i_a + i_b;
      c_ALU_SLL:     o_out = i_a << w_shamt;
      c_ALU_SLT:     o_out = {31'd0, $signed(i_a) < $signed(i_b)};
      c_ALU_SLTU:    o_out = {31'd0, i_a < i_b};
      c_ALU_XOR:     o_out = i_a ^ i_b;
      c_ALU_OR:      o_out = i_a | i_b;
      c_ALU_AND:     o_out = i_a & i_b;
      c_ALU_SRL_SRA: begin
        if (i_funct7 == c_FUNCT7_SRL)
          o_out = i_a >> w_shamt;
        else if (i_funct7 == c_FUNCT7_SRA)
          o_out = DataPath'($signed(i_a) >>> w_shamt);
        else
          o_out = c_ALU_ILLEGAL;
      end
      default:       o_out = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter_rr_arbiter.sv
// ==================================================================
// rr_arbiter: picks the first asserted request at or after i_ptr (wrapping)
// Rev 1.0
// ==================================================================
`default_nettype none

module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_valid
);

  // Winner is the requester with the smallest wrapped distance from the pointer.
  always_comb begin
    int w_best;
    int w_dist;
    w_best  = NUM_REQ;
    w_dist  = 0;
    o_grant = '0;
    o_idx   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_dist = (j + NUM_REQ - int'(i_ptr)) % NUM_REQ;
      if (i_req[j] && (w_dist < w_best)) begin
        w_best     = w_dist;
        o_idx      = ID_W'(j);
        o_grant    = '0;
        o_grant[j] = 1'b1;
      end
    end
    o_valid = (w_best < NUM_REQ);
  end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ==================================================================
// alu_arbiter: round-robin sharing of one ALU with a single tagged result slot
// Rev 1.0
// ==================================================================
`default_nettype none

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic      [NUM_REQ-1:0] reqValid,
  output logic      [NUM_REQ-1:0] reqReady,
  input  DataPath   [NUM_REQ-1:0] reqA,
  input  DataPath   [NUM_REQ-1:0] reqB,
  input  ALUCodePath [NUM_REQ-1:0] reqCode,
  input  Funct7Path [NUM_REQ-1:0] reqFunct7,
  output logic      [NUM_REQ-1:0] respValid,
  input  logic      [NUM_REQ-1:0] respReady,
  output DataPath                respData,
  output logic      [ID_W-1:0]   respId
);

  logic              r_slotValid;
  DataPath           r_slotData;
  logic [ID_W-1:0]   r_slotId;
  logic [ID_W-1:0]   r_rrPtr;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_winIdx;
  logic               w_winValid;
  logic               w_slotFree;
  logic               w_accept;
  logic               w_drain;
  logic [ID_W-1:0]    w_nextPtr;
  ALUReqPath          w_aluReq;
  DataPath            w_aluOut;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req   (reqValid),
    .i_ptr   (r_rrPtr),
    .o_grant (w_grant),
    .o_idx   (w_winIdx),
    .o_valid (w_winValid)
  );

  assign w_aluReq.a      = reqA[w_winIdx];
  assign w_aluReq.b      = reqB[w_winIdx];
  assign w_aluReq.code   = reqCode[w_winIdx];
  assign w_aluReq.funct7 = reqFunct7[w_winIdx];

  alu u_alu (
    .i_a      (w_aluReq.a),
    .i_b      (w_aluReq.b),
    .i_code   (w_aluReq.code),
    .i_funct7 (w_aluReq.funct7),
    .o_out    (w_aluOut)
  );

  // A full slot being drained this cycle can take a new result on the same edge.
  assign w_slotFree = !r_slotValid || respReady[r_slotId];
  assign w_drain    = r_slotValid && respReady[r_slotId];
  assign w_accept   = w_winValid && w_slotFree && !rst;
  assign reqReady   = (w_slotFree && !rst) ? w_grant : '0;
  assign w_nextPtr  = (w_winIdx == ID_W'(NUM_REQ - 1)) ? '0 : w_winIdx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slotValid <= 1'b0;
      r_slotData  <= '0;
      r_slotId    <= '0;
      r_rrPtr     <= '0;
    end else if (w_accept) begin
      r_slotValid <= 1'b1;
      r_slotData  <= w_aluOut;
      r_slotId    <= w_winIdx;
      r_rrPtr     <= w_nextPtr;
    end else if (w_drain) begin
      r_slotValid <= 1'b0;
    end
  end

  always_comb begin
    respValid = '0;
    for (int j = 0; j < NUM_REQ; j++)
      respValid[j] = r_slotValid && (r_slotId == ID_W'(j));
  end

  assign respData = r_slotData;
  assign respId   = r_slotId;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ==================================================================
// tb_alu_arbiter: directed scenarios plus randomized run against a reference model
// Rev 1.0
// ==================================================================
`default_nettype none

module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int N   = 2;
  localparam int IDW = 1;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        reqValid;
  logic [N-1:0]        reqReady;
  DataPath [N-1:0]     reqA;
  DataPath [N-1:0]     reqB;
  ALUCodePath [N-1:0]  reqCode;
  Funct7Path [N-1:0]   reqFunct7;
  logic [N-1:0]        respValid;
  logic [N-1:0]        respReady;
  DataPath             respData;
  logic [IDW-1:0]      respId;

  int n_tests = 0;
  int n_fail  = 0;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .reqValid  (reqValid),
    .reqReady  (reqReady),
    .reqA      (reqA),
    .reqB      (reqB),
    .reqCode   (reqCode),
    .reqFunct7 (reqFunct7),
    .respValid (respValid),
    .respReady (respReady),
    .respData  (respData),
    .respId    (respId)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input DataPath a, input DataPath b,
                         input ALUCodePath c, input Funct7Path f);
    reqA[i]      = a;
    reqB[i]      = b;
    reqCode[i]   = c;
    reqFunct7[i] = f;
  endtask

  // Reference ALU: plain arithmetic on the operation definitions.
  function automatic DataPath alu_ref(input DataPath a, input DataPath b,
                                      input ALUCodePath c, input Funct7Path f);
    int sh;
    sh = int'(b % 32);
    case (c)
      c_ALU_ADD_SUB: return a + b;
      c_ALU_SLL:     return a << sh;
      c_ALU_SLT:     return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      c_ALU_SLTU:    return (a < b) ? 32'd1 : 32'd0;
      c_ALU_XOR:     return a ^ b;
      c_ALU_OR:      return a | b;
      c_ALU_AND:     return a & b;
      default: begin
        if (f == 7'h00)      return a >> sh;
        else if (f == 7'h20) return DataPath'($signed(a) >>> sh);
        else                 return 32'hcdcdcdcd;
      end
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    reqValid = 2'b11;
    #3;
    n_tests++;
    if (reqReady !== 2'b00) begin
      n_fail++; $display("FAIL reset_reqReady: actual=%b expected=00", reqReady);
    end
    @(negedge clk);
    rst = 1'b0;
    reqValid = '0;
    cyc();
    n_tests += 4;
    if (respValid !== 2'b00) begin n_fail++; $display("FAIL idle_respValid: actual=%b expected=00", respValid); end
    if (respData !== 32'd0) begin n_fail++; $display("FAIL idle_respData: actual=%h expected=0", respData); end
    if (respId !== 1'b0) begin n_fail++; $display("FAIL idle_respId: actual=%b expected=0", respId); end
    if (reqReady !== 2'b00) begin n_fail++; $display("FAIL idle_reqReady: actual=%b expected=00", reqReady); end
  endtask

  task automatic test_single();
    set_req(0, 32'd5, 32'd7, c_ALU_ADD_SUB, 7'h00);
    reqValid = 2'b01;
    #1;
    n_tests++;
    if (reqReady !== 2'b01) begin n_fail++; $display("FAIL single_reqReady: actual=%b expected=01", reqReady); end
    cyc();
    reqValid = 2'b00;
    n_tests += 3;
    if (respValid !== 2'b01) begin n_fail++; $display("FAIL single_respValid: actual=%b expected=01", respValid); end
    if (respData !== 32'd12) begin n_fail++; $display("FAIL single_respData: actual=%h expected=0000000c", respData); end
    if (respId !== 1'b0) begin n_fail++; $display("FAIL single_respId: actual=%b expected=0", respId); end
    respReady = 2'b01;
    cyc();
    respReady = 2'b00;
    n_tests += 2;
    if (respValid !== 2'b00) begin n_fail++; $display("FAIL single_drain: actual=%b expected=00", respValid); end
    if (respData !== 32'd12) begin n_fail++; $display("FAIL single_hold: actual=%h expected=0000000c", respData); end
  endtask

  // Pointer sits at 1 after the single-request test, so requester 1 wins first.
  task automatic test_contention();
    int w;
    set_req(0, 32'd1, 32'd1, c_ALU_ADD_SUB, 7'h00);
    set_req(1, 32'hF0, 32'h0F, c_ALU_XOR, 7'h00);
    reqValid  = 2'b11;
    respReady = 2'b11;
    for (int k = 0; k < 4; k++) begin
      w = (k % 2 == 0) ? 1 : 0;
      #1;
      n_tests++;
      if (reqReady !== ((w == 1) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL contention_reqReady[%0d]: actual=%b expected_winner=%0d", k, reqReady, w);
      end
      cyc();
      n_tests += 3;
      if (respValid !== ((w == 1) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL contention_respValid[%0d]: actual=%b expected_winner=%0d", k, respValid, w);
      end
      if (respData !== ((w == 1) ? 32'hFF : 32'd2)) begin
        n_fail++; $display("FAIL contention_respData[%0d]: actual=%h winner=%0d", k, respData, w);
      end
      if (respId !== IDW'(w)) begin
        n_fail++; $display("FAIL contention_respId[%0d]: actual=%b expected=%0d", k, respId, w);
      end
    end
    reqValid = 2'b00;
    cyc();
    respReady = 2'b00;
  endtask

  task automatic test_back_pressure();
    set_req(1, 32'd1, 32'd4, c_ALU_SLL, 7'h00);
    reqValid = 2'b10;
    #1;
    n_tests++;
    if (reqReady !== 2'b10) begin n_fail++; $display("FAIL bp_first_reqReady: actual=%b expected=10", reqReady); end
    cyc();
    reqValid = 2'b01;
    set_req(0, 32'd3, 32'd4, c_ALU_ADD_SUB, 7'h00);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests += 3;
      if (reqReady !== 2'b00) begin n_fail++; $display("FAIL bp_stall_reqReady[%0d]: actual=%b expected=00", k, reqReady); end
      if (respData !== 32'd16) begin n_fail++; $display("FAIL bp_hold_data[%0d]: actual=%h expected=00000010", k, respData); end
      if (respValid !== 2'b10) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: actual=%b expected=10", k, respValid); end
      cyc();
    end
    respReady = 2'b10;
    #1;
    n_tests++;
    if (reqReady !== 2'b01) begin n_fail++; $display("FAIL bp_refill_reqReady: actual=%b expected=01", reqReady); end
    cyc();
    reqValid  = 2'b00;
    respReady = 2'b01;
    n_tests += 3;
    if (respValid !== 2'b01) begin n_fail++; $display("FAIL bp_refill_valid: actual=%b expected=01", respValid); end
    if (respData !== 32'd7) begin n_fail++; $display("FAIL bp_refill_data: actual=%h expected=00000007", respData); end
    if (respId !== 1'b0) begin n_fail++; $display("FAIL bp_refill_id: actual=%b expected=0", respId); end
    cyc();
    respReady = 2'b00;
  endtask

  task automatic test_shifts();
    DataPath    ta [5] = '{32'h80000000, 32'h80000000, 32'd1, 32'h80000000, 32'hFFFFFFFF};
    DataPath    tb [5] = '{32'd4, 32'd4, 32'hFFFFFFFF, 32'd36, 32'd1};
    ALUCodePath tc [5] = '{c_ALU_SRL_SRA, c_ALU_SRL_SRA, c_ALU_SLTU, c_ALU_SRL_SRA, c_ALU_SLT};
    Funct7Path  tf [5] = '{7'h20, 7'h01, 7'h00, 7'h00, 7'h00};
    DataPath    te [5] = '{32'hF8000000, 32'hCDCDCDCD, 32'd1, 32'h08000000, 32'd1};
    respReady = 2'b01;
    for (int k = 0; k < 5; k++) begin
      set_req(0, ta[k], tb[k], tc[k], tf[k]);
      reqValid = 2'b01;
      cyc();
      n_tests += 2;
      if (respValid !== 2'b01) begin n_fail++; $display("FAIL shift_valid[%0d]: actual=%b expected=01", k, respValid); end
      if (respData !== te[k]) begin n_fail++; $display("FAIL shift_data[%0d]: actual=%h expected=%h", k, respData, te[k]); end
    end
    reqValid = 2'b00;
    cyc();
    respReady = 2'b00;
  endtask

  task automatic test_reset_midflight();
    set_req(0, 32'd1, 32'd2, c_ALU_ADD_SUB, 7'h00);
    reqValid = 2'b01;
    cyc();
    n_tests++;
    if (respValid !== 2'b01) begin n_fail++; $display("FAIL mid_full: actual=%b expected=01", respValid); end
    set_req(1, 32'd10, 32'd20, c_ALU_ADD_SUB, 7'h00);
    reqValid = 2'b11;
    #2;
    rst = 1'b1;
    #1;
    n_tests += 3;
    if (respValid !== 2'b00) begin n_fail++; $display("FAIL mid_async_valid: actual=%b expected=00", respValid); end
    if (respData !== 32'd0) begin n_fail++; $display("FAIL mid_async_data: actual=%h expected=0", respData); end
    if (reqReady !== 2'b00) begin n_fail++; $display("FAIL mid_async_ready: actual=%b expected=00", reqReady); end
    #1;
    rst = 1'b0;
    #1;
    n_tests++;
    if (reqReady !== 2'b01) begin n_fail++; $display("FAIL mid_ptr_reset: actual=%b expected=01", reqReady); end
    reqValid = 2'b10;
    #1;
    n_tests++;
    if (reqReady !== 2'b10) begin n_fail++; $display("FAIL mid_req1_ready: actual=%b expected=10", reqReady); end
    cyc();
    n_tests += 3;
    if (respValid !== 2'b10) begin n_fail++; $display("FAIL mid_req1_valid: actual=%b expected=10", respValid); end
    if (respId !== 1'b1) begin n_fail++; $display("FAIL mid_req1_id: actual=%b expected=1", respId); end
    if (respData !== 32'd30) begin n_fail++; $display("FAIL mid_req1_data: actual=%h expected=0000001e", respData); end
    reqValid  = 2'b00;
    respReady = 2'b11;
    cyc();
    respReady = 2'b00;
  endtask

  task automatic test_random();
    DataPath    pa [N];
    DataPath    pb [N];
    ALUCodePath pc [N];
    Funct7Path  pf [N];
    bit         pend [N];
    bit         m_valid;
    DataPath    m_data;
    int         m_id;
    int         m_ptr;
    int         w;
    int         j;
    bit         free;
    logic [N-1:0] exp_rv;
    logic [N-1:0] exp_rr;
    int         r;

    rst = 1'b1;
    reqValid = '0;
    respReady = '0;
    #3;
    rst = 1'b0;
    cyc();
    m_valid = 0; m_data = '0; m_id = 0; m_ptr = 0;
    for (int i = 0; i < N; i++) pend[i] = 0;

    for (int c = 0; c < 400; c++) begin
      exp_rv = '0;
      if (m_valid) exp_rv[m_id] = 1'b1;
      n_tests += 3;
      if (respValid !== exp_rv) begin n_fail++; $display("FAIL rand_respValid[%0d]: actual=%b expected=%b", c, respValid, exp_rv); end
      if (respData !== m_data) begin n_fail++; $display("FAIL rand_respData[%0d]: actual=%h expected=%h", c, respData, m_data); end
      if (respId !== IDW'(m_id)) begin n_fail++; $display("FAIL rand_respId[%0d]: actual=%b expected=%0d", c, respId, m_id); end

      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
          pend[i] = 1;
          pa[i] = $urandom();
          pb[i] = ($urandom_range(0, 1) == 1) ? DataPath'($urandom_range(0, 40)) : DataPath'($urandom());
          pc[i] = ALUCodePath'($urandom_range(0, 7));
          r = $urandom_range(0, 9);
          pf[i] = (r < 4) ? 7'h00 : (r < 8) ? 7'h20 : Funct7Path'($urandom_range(0, 127));
        end
        if (pend[i]) set_req(i, pa[i], pb[i], pc[i], pf[i]);
        reqValid[i] = pend[i];
      end
      respReady = N'($urandom_range(0, (1 << N) - 1));
      #1;

      w = -1;
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (w < 0 && pend[j]) w = j;
      end
      free = !m_valid || respReady[m_id];
      exp_rr = '0;
      if (w >= 0 && free) exp_rr[w] = 1'b1;
      n_tests++;
      if (reqReady !== exp_rr) begin n_fail++; $display("FAIL rand_reqReady[%0d]: actual=%b expected=%b", c, reqReady, exp_rr); end

      if (w >= 0 && free) begin
        m_data  = alu_ref(pa[w], pb[w], pc[w], pf[w]);
        m_id    = w;
        m_valid = 1;
        m_ptr   = (w + 1) % N;
        pend[w] = 0;
      end else if (m_valid && respReady[m_id]) begin
        m_valid = 0;
      end
      cyc();
    end
    reqValid  = '0;
    respReady = '0;
  endtask

  initial begin
    rst       = 1'b0;
    reqValid  = '0;
    respReady = '0;
    reqA      = '0;
    reqB      = '0;
    reqCode   = '0;
    reqFunct7 = '0;
    test_reset();
    test_single();
    test_contention();
    test_back_pressure();
    test_shifts();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
